// File: rtl/stack_pkg.sv
// Shared encodings for the stack-pointer engine: operation codes and FSM states.
// STACK_GUARD_EN adds the sticky FAULT state.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_PUSH = 3'b001,
        OP_POP  = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100,
        OP_LDSP = 3'b101,
        OP_ADJ  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef STACK_GUARD_EN
        ST_MEM   = 2'd1,
        ST_FAULT = 2'd2
`else
        ST_MEM   = 2'd1
`endif
    } state_e;

endpackage

// File: rtl/stack_bound_check.sv
// Combinational range check of a candidate stack pointer against the legal window
// [STACK_TOP-DEPTH, STACK_TOP], plus full/empty flags of the current pointer.
module stack_bound_check #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned STACK_TOP = 1023,
    parameter int unsigned DEPTH     = 1023
) (
    input  logic [ADDR_W-1:0] sp_i,
    input  logic [ADDR_W-1:0] cand_i,
    output logic              in_range_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(STACK_TOP);
    localparam logic [ADDR_W-1:0] BOT = ADDR_W'(STACK_TOP - DEPTH);

    assign in_range_o = (cand_i >= BOT) && (cand_i <= TOP);
    assign full_o     = (sp_i == BOT);
    assign empty_o    = (sp_i == TOP);

endmodule

// File: rtl/stack_pointer_unit.sv
// Full-descending stack-pointer engine driving one data-memory port.
// Define STACK_GUARD_EN to trap overflow/underflow/out-of-window SP into a sticky FAULT state.
module stack_pointer_unit
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned STACK_TOP = 1023,
    parameter int unsigned DEPTH     = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [2:0]                   op,
    input  logic [ADDR_W-1:0]            op_data,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [ADDR_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic [ADDR_W-1:0]            mem_rdata,
    output logic                         done,
    output logic [ADDR_W-1:0]            rd_data,
    output logic [ADDR_W-1:0]            sp,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         fault
);

    localparam int unsigned       DEPTH_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] TOP     = ADDR_W'(STACK_TOP);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] rd_data_q, rd_data_d;

    logic [ADDR_W-1:0] sp_dec, sp_inc, sp_adj;
    logic              full_w, empty_w;
    logic              guard_trip;

    assign sp_dec = sp_q - 1'b1;
    assign sp_inc = sp_q + 1'b1;
    assign sp_adj = sp_q + op_data;

`ifdef STACK_GUARD_EN
    logic              fault_q, fault_d;
    logic              cand_ok;
    logic [ADDR_W-1:0] cand;

    assign cand = (op_e'(op) == OP_LDSP) ? op_data : sp_adj;

    stack_bound_check #(
        .ADDR_W   (ADDR_W),
        .STACK_TOP(STACK_TOP),
        .DEPTH    (DEPTH)
    ) u_bound (
        .sp_i      (sp_q),
        .cand_i    (cand),
        .in_range_o(cand_ok),
        .full_o    (full_w),
        .empty_o   (empty_w)
    );

    always_comb begin
        guard_trip = 1'b0;
        case (op_e'(op))
            OP_PUSH, OP_CALL: guard_trip = full_w;
            OP_POP,  OP_RET:  guard_trip = empty_w;
            OP_LDSP, OP_ADJ:  guard_trip = !cand_ok;
            default:          guard_trip = 1'b0;
        endcase
    end

    assign fault = fault_q;
`else
    assign full_w     = (sp_q == ADDR_W'(STACK_TOP - DEPTH));
    assign empty_w    = (sp_q == TOP);
    assign guard_trip = 1'b0;
    assign fault      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        rd_data_d   = rd_data_q;
`ifdef STACK_GUARD_EN
        fault_d     = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (op_valid && guard_trip) begin
`ifdef STACK_GUARD_EN
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
`endif
                end else if (op_valid) begin
                    case (op_e'(op))
                        OP_PUSH, OP_CALL: begin
                            sp_d        = sp_dec;
                            mem_addr_d  = sp_dec;
                            mem_wdata_d = op_data;
                            mem_we_d    = 1'b1;
                            mem_req_d   = 1'b1;
                            state_d     = ST_MEM;
                        end
                        OP_POP, OP_RET: begin
                            sp_d       = sp_inc;
                            mem_addr_d = sp_q;
                            mem_we_d   = 1'b0;
                            mem_req_d  = 1'b1;
                            state_d    = ST_MEM;
                        end
                        OP_LDSP: begin
                            sp_d   = op_data;
                            done_d = 1'b1;
                        end
                        OP_ADJ: begin
                            sp_d   = sp_adj;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!mem_we_q) rd_data_d = mem_rdata;
                    state_d   = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sp_q        <= TOP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
`ifdef STACK_GUARD_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
`ifdef STACK_GUARD_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign op_ready  = (state_q == ST_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign sp        = sp_q;
    assign depth     = DEPTH_W'(TOP - sp_q);
    assign full      = full_w;
    assign empty     = empty_w;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed self-checking bench for stack_pointer_unit with default parameters.
// Guard behaviour checked according to whether STACK_GUARD_EN is defined.
module tb_stack_pointer_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] op_data = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        done;
    logic [31:0] rd_data, sp;
    logic [9:0]  depth;
    logic        full, empty, fault;

    int total = 0;
    int bad   = 0;

    stack_pointer_unit #(.ADDR_W(32), .STACK_TOP(1023), .DEPTH(1023)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .op_data(op_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .done(done),
        .rd_data(rd_data), .sp(sp), .depth(depth), .full(full), .empty(empty), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        op_valid = 1'b0; mem_ack = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (sp !== 32'd1023) begin bad++; $display("FAIL reset_sp got=%0d exp=1023", sp); end
        total++; if ({mem_req, mem_we, done, fault, op_ready} !== 5'b00001) begin bad++;
            $display("FAIL reset_flags got=%b exp=00001", {mem_req, mem_we, done, fault, op_ready}); end
        total++; if ({mem_addr, mem_wdata, rd_data} !== 96'd0) begin bad++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", mem_addr, mem_wdata, rd_data); end
        total++; if ({empty, full, depth} !== {1'b1, 1'b0, 10'd0}) begin bad++;
            $display("FAIL reset_level got=%b%b %0d exp=10 0", empty, full, depth); end
    endtask

    task automatic test_push();
        op = 3'b001; op_data = 32'hA5; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        total++; if ({mem_req, mem_we, op_ready} !== 3'b110 || mem_addr !== 32'd1022 || mem_wdata !== 32'hA5) begin bad++;
            $display("FAIL push_issue got=%b addr=%0d wd=%h exp=110 1022 a5", {mem_req, mem_we, op_ready}, mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        total++; if ({done, mem_req, op_ready} !== 3'b101 || sp !== 32'd1022 || depth !== 10'd1) begin bad++;
            $display("FAIL push_done got=%b sp=%0d depth=%0d exp=101 1022 1", {done, mem_req, op_ready}, sp, depth); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL push_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_pop_delayed();
        op = 3'b010; op_valid = 1'b1; mem_rdata = 32'hA5;
        step();
        op_valid = 1'b0;
        total++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'd1022) begin bad++;
            $display("FAIL pop_issue got=%b addr=%0d exp=10 1022", {mem_req, mem_we}, mem_addr); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({mem_req, done} !== 2'b10) begin bad++;
                $display("FAIL pop_hold%0d got=%b exp=10", i, {mem_req, done}); end
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        total++; if ({mem_req, done, empty} !== 3'b011 || rd_data !== 32'hA5 || sp !== 32'd1023) begin bad++;
            $display("FAIL pop_done got=%b rd=%h sp=%0d exp=011 a5 1023", {mem_req, done, empty}, rd_data, sp); end
        step();
        total++; if (rd_data !== 32'hA5) begin bad++; $display("FAIL pop_rd_hold got=%h exp=a5", rd_data); end
    endtask

    task automatic test_call_ret();
        apply_reset();
        op = 3'b011; op_data = 32'h40; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        total++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'd1022 || mem_wdata !== 32'h40) begin bad++;
            $display("FAIL call_issue got=%b addr=%0d wd=%h exp=11 1022 40", {mem_req, mem_we}, mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        op = 3'b100; op_valid = 1'b1; mem_rdata = 32'h40;
        step();
        op_valid = 1'b0;
        total++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'd1022) begin bad++;
            $display("FAIL ret_issue got=%b addr=%0d exp=10 1022", {mem_req, mem_we}, mem_addr); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        total++; if (done !== 1'b1 || rd_data !== 32'h40 || sp !== 32'd1023) begin bad++;
            $display("FAIL ret_done got=%b rd=%h sp=%0d exp=1 40 1023", done, rd_data, sp); end
    endtask

    task automatic test_ldsp_adj();
        apply_reset();
        op = 3'b101; op_data = 32'h200; op_valid = 1'b1;
        step();
        total++; if ({done, mem_req, op_ready} !== 3'b101 || sp !== 32'h200) begin bad++;
            $display("FAIL ldsp got=%b sp=%h exp=101 200", {done, mem_req, op_ready}, sp); end
        op = 3'b110; op_data = 32'hFFFF_FFFC;
        step();
        op_valid = 1'b0;
        total++; if ({done, mem_req} !== 2'b10 || sp !== 32'h1FC || depth !== 10'd515) begin bad++;
            $display("FAIL adj got=%b sp=%h depth=%0d exp=10 1fc 515", {done, mem_req}, sp, depth); end
        op = 3'b101; op_data = 32'h0; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        total++; if ({full, empty} !== 2'b10 || depth !== 10'd1023) begin bad++;
            $display("FAIL full_flag got=%b depth=%0d exp=10 1023", {full, empty}, depth); end
    endtask

    task automatic test_nop_stray_ack();
        apply_reset();
        op = 3'b000; op_valid = 1'b1;
        step();
        op = 3'b111;
        step();
        op_valid = 1'b0;
        total++; if ({done, mem_req, op_ready} !== 3'b001 || sp !== 32'd1023) begin bad++;
            $display("FAIL nop got=%b sp=%0d exp=001 1023", {done, mem_req, op_ready}, sp); end
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        step();
        mem_ack = 1'b0;
        step();
        total++; if (done !== 1'b0 || rd_data !== 32'h0) begin bad++;
            $display("FAIL stray_ack got=%b rd=%h exp=0 0", done, rd_data); end
    endtask

    task automatic test_guard();
        apply_reset();
        op = 3'b010; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
`ifdef STACK_GUARD_EN
        total++; if ({fault, op_ready, mem_req, done} !== 4'b1000 || sp !== 32'd1023) begin bad++;
            $display("FAIL guard_pop got=%b sp=%0d exp=1000 1023", {fault, op_ready, mem_req, done}, sp); end
        op = 3'b101; op_data = 32'd5; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        total++; if ({fault, op_ready} !== 2'b10 || sp !== 32'd1023) begin bad++;
            $display("FAIL guard_sticky got=%b sp=%0d exp=10 1023", {fault, op_ready}, sp); end
        apply_reset();
        total++; if ({fault, op_ready} !== 2'b01) begin bad++;
            $display("FAIL guard_clear got=%b exp=01", {fault, op_ready}); end
        op = 3'b101; op_data = 32'd2000; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        total++; if ({fault, done} !== 2'b10 || sp !== 32'd1023) begin bad++;
            $display("FAIL guard_ldsp got=%b sp=%0d exp=10 1023", {fault, done}, sp); end
`else
        total++; if ({mem_req, mem_we, fault} !== 3'b100 || mem_addr !== 32'd1023 || sp !== 32'h400) begin bad++;
            $display("FAIL wrap_pop got=%b addr=%0d sp=%h exp=100 1023 400", {mem_req, mem_we, fault}, mem_addr, sp); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        total++; if ({done, fault} !== 2'b10 || sp !== 32'h400) begin bad++;
            $display("FAIL wrap_done got=%b sp=%h exp=10 400", {done, fault}, sp); end
`endif
    endtask

    task automatic test_rst_in_mem();
        apply_reset();
        op = 3'b001; op_data = 32'h77; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstmem_req got=%b exp=1", mem_req); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if ({mem_req, op_ready} !== 2'b01 || sp !== 32'd1023 || mem_addr !== 32'd0) begin bad++;
            $display("FAIL rstmem_abort got=%b sp=%0d addr=%0d exp=01 1023 0", {mem_req, op_ready}, sp, mem_addr); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        total++; if (done !== 1'b0 || sp !== 32'd1023) begin bad++;
            $display("FAIL rstmem_late_ack got=%b sp=%0d exp=0 1023", done, sp); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        op = 3'b001; op_data = 32'h11; op_valid = 1'b1;
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        total++; if ({done, mem_req, op_ready} !== 3'b101 || sp !== 32'd1022) begin bad++;
            $display("FAIL b2b_hold got=%b sp=%0d exp=101 1022", {done, mem_req, op_ready}, sp); end
        op_data = 32'h22;
        step();
        op_valid = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'd1021 || mem_wdata !== 32'h22 || sp !== 32'd1021) begin bad++;
            $display("FAIL b2b_second got=%b addr=%0d wd=%h sp=%0d exp=1 1021 22 1021", mem_req, mem_addr, mem_wdata, sp); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        total++; if (done !== 1'b1 || depth !== 10'd2) begin bad++;
            $display("FAIL b2b_done got=%b depth=%0d exp=1 2", done, depth); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop_delayed();
        test_call_ret();
        test_ldsp_adj();
        test_nop_stray_ack();
        test_guard();
        test_rst_in_mem();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
